writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback stage and architectural register file of the RV32E core, sitting directly downstream of the MEMEX→WB pipeline register. Commits valid WB-stage results into 16×32-bit registers (x0 hardwired to zero) and serves two combinational read ports to decode, with same-cycle write-to-read bypass. Also maintains 64-bit cycle and retired-instruction counters for the future CSR block.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_REGS, 16, architectural registers (RV32E)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- invalid_WB  in  1  WB slot holds a bubble/squashed instruction
- rd_WB  in  4  destination register index
- alu_result_WB  in  32  result to commit
- regfile_we_WB  in  1  instruction writes rd
- rs1_ID, rs2_ID  in  4 each  decode-stage read indices
- rs1_data_ID, rs2_data_ID  out  32 each  read data, combinational
- wb_fwd_valid  out  1  a register commit happens this cycle
- wb_fwd_rd  out  4  index being committed (rd_WB)
- wb_fwd_data  out  32  value being committed (alu_result_WB)
- cycle  out  64  cycles since reset
- instret  out  64  instructions retired since reset

## Operation
- commit = regfile_we_WB && !invalid_WB && rd_WB != 0 && !rst.
- On posedge with commit: regs[rd_WB] <= alu_result_WB. Writes to x0 are discarded; x0 has no storage and always reads 0.
- retire = !invalid_WB && !rst. Every retired instruction increments instret, whether or not it writes (stores, branches, rd=x0 included).
- cycle increments on every posedge with rst low.
- Read port n (n = 1, 2): if rst → 0; else if rsn_ID == 0 → 0; else if commit && rsn_ID == rd_WB → alu_result_WB (bypass); else regs[rsn_ID].
- Both ports may read the same index; both get the same value.
- wb_fwd_valid = commit; wb_fwd_rd = rd_WB; wb_fwd_data = alu_result_WB (unqualified; consumers gate on wb_fwd_valid).
- Counters wrap from 2^64−1 to 0 with no flag.
- No stall input: the WB stage never stalls. Upstream holds its outputs during stall, so a held valid instruction would retire twice. Upstream must therefore present invalid_WB = 1 for every stalled cycle after the first.

## Timing
- Reset (rst high at posedge): regs[1..15], cycle, and instret become 0. WB inputs are ignored in that cycle.
- Outputs while rst is high: rs*_data_ID = 0, wb_fwd_valid = 0, cycle = 0 and instret = 0 from the first reset edge.
- Write latency: a value committed at edge k is visible from the array after edge k. Before edge k it is visible through the bypass in the same cycle. Effective read-after-write latency is 0 cycles.
- Counter outputs are registered. cycle reads N after N non-reset edges.
- Reset asserted mid-operation takes priority over any simultaneous commit or retire. That instruction is lost and not counted.
- The MEMEX→WB register is not reset. The bench and integration must hold invalid_WB = 1 until the first real instruction arrives.

## Structure
- Shared package rv32e_pkg: XLEN, NUM_REGS, reg_idx_t (logic [3:0]), word_t (logic [31:0]), REG_ZERO = 4'd0.
- One sub-module, counter64: 64-bit synchronous-reset counter with an increment enable. Instantiated twice (cycle, instret).
- Register array is 15 entries (1..15) of flops inside the top module; no RAM inference required.

## Test plan
- Reset: rst high 2 cycles with a prior write to x5 → rs1_ID = 5 reads 0; cycle = 0; instret = 0.
- Write/read: commit x3 = 32'hDEADBEEF → same-cycle rs2_ID = 3 returns DEADBEEF via bypass. Next cycle, with invalid_WB = 1, it still returns DEADBEEF.
- x0 protection: regfile_we_WB = 1, rd_WB = 0, data 32'h1234 → rs1_ID = 0 reads 0; wb_fwd_valid = 0; instret += 1.
- Bubble and non-writing instructions: invalid_WB = 1 with we = 1 to x7 → x7 unchanged, instret unchanged. invalid_WB = 0 with we = 0 → instret += 1, no write.
- Reset priority: rst and a valid commit to x9 = 5 in the same cycle → x9 = 0 afterwards; instret = 0.
- Wrap: force instret to 64'hFFFF_FFFF_FFFF_FFFF, retire one → 0.

Source files
------------

// File: rtl/rv32e_pkg.sv
// Shared RV32E types and constants for the writeback/register-file slice.
package rv32e_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 16;

    typedef logic [3:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 4'd0;

    // Architectural write: real instruction, writes rd, rd is not x0.
    function automatic logic is_commit(input logic we, input logic invalid,
                                       input reg_idx_t rd, input logic rst);
        return we && !invalid && (rd != REG_ZERO) && !rst;
    endfunction

endpackage

// File: rtl/counter64.sv
// 64-bit free-running counter with synchronous active-high reset and increment enable.
module counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // Wraps from all-ones to zero silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/writeback_regfile.sv
// RV32E writeback stage: 15-entry register file (x0 hardwired), two bypassed read ports,
// commit forwarding, and cycle/instret counters.
module writeback_regfile
    import rv32e_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            invalid_WB,
    input  reg_idx_t        rd_WB,
    input  logic [XLEN-1:0] alu_result_WB,
    input  logic            regfile_we_WB,
    input  reg_idx_t        rs1_ID,
    input  reg_idx_t        rs2_ID,
    output logic [XLEN-1:0] rs1_data_ID,
    output logic [XLEN-1:0] rs2_data_ID,
    output logic            wb_fwd_valid,
    output reg_idx_t        wb_fwd_rd,
    output logic [XLEN-1:0] wb_fwd_data,
    output logic [63:0]     cycle,
    output logic [63:0]     instret
);

    logic            w_commit;
    logic            w_retire;
    logic [XLEN-1:0] r_regs [1:NUM_REGS-1];

    assign w_commit = is_commit(regfile_we_WB, invalid_WB, rd_WB, rst);
    assign w_retire = !invalid_WB && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[rd_WB] <= alu_result_WB;
        end
    end

    // x0 has no storage; same-cycle commit wins over the stored value.
    function automatic logic [XLEN-1:0] read_port(input reg_idx_t idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (rst || idx == REG_ZERO) begin
            v = '0;
        end else if (w_commit && idx == rd_WB) begin
            v = alu_result_WB;
        end else begin
            v = r_regs[idx];
        end
        return v;
    endfunction

    always_comb begin
        rs1_data_ID = read_port(rs1_ID);
        rs2_data_ID = read_port(rs2_ID);
    end

    assign wb_fwd_valid = w_commit;
    assign wb_fwd_rd    = rd_WB;
    assign wb_fwd_data  = alu_result_WB;

    counter64 u_cycle (
        .clk     (clk),
        .rst     (rst),
        .i_en    (1'b1),
        .o_count (cycle)
    );

    counter64 u_instret (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_retire),
        .o_count (instret)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: reference model predicts read ports,
// forward outputs and counters for each driven cycle.
module tb_writeback_regfile;
    import rv32e_pkg::*;

    logic        clk;
    logic        rst;
    logic        invalid_WB;
    reg_idx_t    rd_WB;
    logic [31:0] alu_result_WB;
    logic        regfile_we_WB;
    reg_idx_t    rs1_ID;
    reg_idx_t    rs2_ID;
    logic [31:0] rs1_data_ID;
    logic [31:0] rs2_data_ID;
    logic        wb_fwd_valid;
    reg_idx_t    wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic [63:0] cycle;
    logic [63:0] instret;

    writeback_regfile #(.XLEN(32), .NUM_REGS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .invalid_WB    (invalid_WB),
        .rd_WB         (rd_WB),
        .alu_result_WB (alu_result_WB),
        .regfile_we_WB (regfile_we_WB),
        .rs1_ID        (rs1_ID),
        .rs2_ID        (rs2_ID),
        .rs1_data_ID   (rs1_data_ID),
        .rs2_data_ID   (rs2_data_ID),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .cycle         (cycle),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        fv;
        logic [3:0]  frd;
        logic [31:0] fdata;
        logic [63:0] cyc;
        logic [63:0] ins;
        logic        cnt_known;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [16];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        m_known;
    int          n_cmp;
    int          n_bad;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic r, input logic [3:0] idx,
                                           input logic c, input logic [3:0] rd,
                                           input logic [31:0] d);
        if (r || idx == 4'd0) return 32'd0;
        if (c && idx == rd) return d;
        return m_regs[idx];
    endfunction

    // One cycle: drive at negedge, predict, compare after settling, then
    // advance the model to match the following posedge.
    task automatic step(input logic r, input logic inv, input logic we,
                        input logic [3:0] rd, input logic [31:0] d,
                        input logic [3:0] a1, input logic [3:0] a2);
        exp_t e;
        exp_t g;
        logic c;
        @(negedge clk);
        rst = r; invalid_WB = inv; regfile_we_WB = we; rd_WB = rd;
        alu_result_WB = d; rs1_ID = a1; rs2_ID = a2;
        c = we && !inv && (rd != 4'd0) && !r;
        e.rs1 = m_read(r, a1, c, rd, d);
        e.rs2 = m_read(r, a2, c, rd, d);
        e.fv = c; e.frd = rd; e.fdata = d;
        e.cyc = m_cycle; e.ins = m_instret; e.cnt_known = m_known;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        check_eq("rs1_data", {32'd0, rs1_data_ID}, {32'd0, g.rs1});
        check_eq("rs2_data", {32'd0, rs2_data_ID}, {32'd0, g.rs2});
        check_eq("fwd_valid", {63'd0, wb_fwd_valid}, {63'd0, g.fv});
        check_eq("fwd_rd", {60'd0, wb_fwd_rd}, {60'd0, g.frd});
        check_eq("fwd_data", {32'd0, wb_fwd_data}, {32'd0, g.fdata});
        if (g.cnt_known) begin
            check_eq("cycle", cycle, g.cyc);
            check_eq("instret", instret, g.ins);
        end
        if (r) begin
            for (int i = 1; i < 16; i++) m_regs[i] = 32'd0;
            m_cycle = 64'd0;
            m_instret = 64'd0;
            m_known = 1'b1;
        end else begin
            if (c) m_regs[rd] = d;
            m_cycle = m_cycle + 64'd1;
            if (!inv) m_instret = m_instret + 64'd1;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_known = 1'b0; m_cycle = '0; m_instret = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        rst = 1'b1; invalid_WB = 1'b1; regfile_we_WB = 1'b0; rd_WB = '0;
        alu_result_WB = '0; rs1_ID = '0; rs2_ID = '0;

        step(1, 1, 0, 4'd0, 32'd0, 4'd0, 4'd0);
        step(1, 1, 0, 4'd0, 32'd0, 4'd5, 4'd5);
        // write x5, then reset for two cycles and confirm it is gone
        step(0, 0, 1, 4'd5, 32'hAAAA_5555, 4'd5, 4'd0);
        step(0, 1, 0, 4'd0, 32'd0, 4'd5, 4'd5);
        step(1, 1, 0, 4'd0, 32'd0, 4'd5, 4'd5);
        step(1, 0, 1, 4'd5, 32'h1111_2222, 4'd5, 4'd5);
        step(0, 1, 0, 4'd0, 32'd0, 4'd5, 4'd0);
        // write/read with bypass, then array read
        step(0, 0, 1, 4'd3, 32'hDEAD_BEEF, 4'd1, 4'd3);
        step(0, 1, 0, 4'd0, 32'd0, 4'd3, 4'd3);
        // x0 protection
        step(0, 0, 1, 4'd0, 32'h0000_1234, 4'd0, 4'd3);
        step(0, 1, 0, 4'd0, 32'd0, 4'd0, 4'd0);
        // bubble with we set, then non-writing retire
        step(0, 1, 1, 4'd7, 32'hCAFE_F00D, 4'd7, 4'd7);
        step(0, 0, 0, 4'd7, 32'h0BAD_0BAD, 4'd7, 4'd3);
        step(0, 1, 0, 4'd0, 32'd0, 4'd7, 4'd0);

        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom(),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // reset priority over a simultaneous commit to x9
        step(0, 0, 1, 4'd9, 32'h0000_0077, 4'd9, 4'd0);
        step(1, 0, 1, 4'd9, 32'h0000_0005, 4'd9, 4'd9);
        step(0, 1, 0, 4'd0, 32'd0, 4'd9, 4'd9);
        step(0, 1, 0, 4'd0, 32'd0, 4'd9, 4'd0);

        // instret wrap
        @(posedge clk);
        #1;
        force dut.u_instret.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_instret.r_count;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        step(0, 0, 0, 4'd0, 32'd0, 4'd0, 4'd0);
        step(0, 1, 0, 4'd0, 32'd0, 4'd9, 4'd3);
        step(0, 1, 0, 4'd0, 32'd0, 4'd0, 4'd0);

        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
